// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use, mispredict and MDU hazards.
// Optional statistics counters enabled with `define HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             uses_rs_d,
    input  logic             uses_rt_d,
    input  logic [4:0]       rd_e,
    input  logic             regwrite_e,
    input  logic             memtoreg_e,
    input  logic             mispredict_e,
    input  logic             mdu_start_d,
    input  logic             mdu_use_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             mdu_go,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             mdu_busy
);

    localparam int CW = $clog2(MDU_LAT);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_use;
    logic            mdu_hz;
    logic            hold;

    assign mdu_busy = (state_q == BUSY);

    // Strobes are forced low while reset is asserted, since they are combinational.
    always_comb begin
        load_use = memtoreg_e & regwrite_e & (rd_e != '0) &
                   ((uses_rs_d & (rs_d == rd_e)) | (uses_rt_d & (rt_d == rd_e)));
        mdu_hz   = mdu_busy & (mdu_start_d | mdu_use_d);
        hold     = rst_n & ~mispredict_e & (load_use | mdu_hz);
        stall_f  = hold;
        stall_d  = hold;
        flush_d  = rst_n & mispredict_e;
        flush_e  = (rst_n & mispredict_e) | hold;
        mdu_go   = rst_n & mdu_start_d & ~mispredict_e & ~load_use & ~mdu_hz;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mdu_go) begin
                    state_d = BUSY;
                    cnt_d   = CW'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_d && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (mispredict_e && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MDU_LAT=4, CNT_W=2); stats checks under HAZARD_STATS_EN.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [5:0] o;      // {stall_f, stall_d, flush_d, flush_e, mdu_go, mdu_busy}
        logic       chk;    // compare statistics counters this cycle
        logic [1:0] sc;
        logic [1:0] fc;
        int         id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_d = '0, rt_d = '0, rd_e = '0;
    logic       uses_rs_d = 1'b0, uses_rt_d = 1'b0, regwrite_e = 1'b0, memtoreg_e = 1'b0;
    logic       mispredict_e = 1'b0, mdu_start_d = 1'b0, mdu_use_d = 1'b0;
    logic       stall_f, stall_d, flush_d, flush_e, mdu_go, mdu_busy;
    logic [1:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
        .rd_e(rd_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .mispredict_e(mispredict_e), .mdu_start_d(mdu_start_d), .mdu_use_d(mdu_use_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .mdu_go(mdu_go),
`ifdef HAZARD_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .mdu_busy(mdu_busy)
    );

`ifndef HAZARD_STATS_EN
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e   = q.pop_front();
            act = {stall_f, stall_d, flush_d, flush_e, mdu_go, mdu_busy};
            checks++;
            if (act !== e.o) begin
                errors++;
                $display("FAIL outputs c%0d: got sf/sd/fd/fe/go/busy=%b expected %b", e.id, act, e.o);
            end
`ifdef HAZARD_STATS_EN
            if (e.chk) begin
                checks++;
                if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL stats c%0d: got stall_cnt=%0d flush_cnt=%0d expected %0d/%0d",
                             e.id, stall_cnt, flush_cnt, e.sc, e.fc);
                end
            end
`endif
        end
    end

    // rs rt urs urt rd_e rw mtr mp ms mu | expected outputs, optional stats
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rde,
                        input logic rw, input logic mtr, input logic mp, input logic ms,
                        input logic mu, input logic [5:0] eo,
                        input logic chk = 1'b0, input logic [1:0] sc = 2'd0,
                        input logic [1:0] fc = 2'd0);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; rs_d = rs; rt_d = rt; uses_rs_d = urs; uses_rt_d = urt; rd_e = rde;
        regwrite_e = rw; memtoreg_e = mtr; mispredict_e = mp; mdu_start_d = ms; mdu_use_d = mu;
        e.o = eo; e.chk = chk; e.sc = sc; e.fc = fc; e.id = cyc;
        q.push_back(e);
        cyc++;
    endtask

    initial begin
        // c0: in reset with hazard inputs asserted -> everything low, stats zero
        step(0, 5, 0, 1, 0, 5, 1, 1, 0, 1, 0, 6'b000000, 1, 0, 0);
        // c1: load-use on rs; c2: clear
        step(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 6'b110100);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
        // c3: rd_e=0 never stalls; c4: regwrite_e=0 never stalls
        step(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 6'b000000);
        step(1, 0, 7, 0, 1, 7, 0, 1, 0, 0, 0, 6'b000000);
        // c5: load-use on rt
        step(1, 0, 9, 0, 1, 9, 1, 1, 0, 0, 0, 6'b110100);
        // c6 t0: MDU start accepted; c7 t1 busy; c8-c10 mfhi stalls; c11 proceeds
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b110101);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b110101);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b110101);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000);
        // c12: mispredict beats load-use and MDU start; c13: start was squashed
        step(1, 3, 0, 1, 0, 3, 1, 1, 1, 1, 0, 6'b001100);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
        // c14 start; c15 mispredict while busy keeps counting; c16-c18 start stalls; c19 accepted
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001101);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b110101);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b110101);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b110101);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
        // c20 busy cnt=3; c21 reset at cnt=2; c22 start accepted at once; c23 busy
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000000, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000010, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001);
        // c24-c28: five load-use stall cycles (MDU still busy through c26)
        step(1, 4, 0, 1, 0, 4, 1, 1, 0, 0, 0, 6'b110101);
        step(1, 4, 0, 1, 0, 4, 1, 1, 0, 0, 0, 6'b110101);
        step(1, 4, 0, 1, 0, 4, 1, 1, 0, 0, 0, 6'b110101);
        step(1, 4, 0, 1, 0, 4, 1, 1, 0, 0, 0, 6'b110100);
        step(1, 4, 0, 1, 0, 4, 1, 1, 0, 0, 0, 6'b110100, 1, 3, 0);
        // c29-c30: two mispredicts; c31 counters settled
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001100, 1, 3, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001100, 1, 3, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 3, 2);

        for (int unsigned i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never compared, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
